// File: rtl/lfsr_mod_pkg.sv
// Shared types for the LFSR-driven modulator: modulation select and FSM states.
package lfsr_mod_pkg;

    typedef enum logic [1:0] {
        MOD_ASK  = 2'd0,
        MOD_FSK  = 2'd1,
        MOD_BPSK = 2'd2,
        MOD_QPSK = 2'd3
    } mod_sel_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/lfsr_modulator_if.sv
// DDS-side bundle: samples and increments in, modulated sample and symbol out.
interface lfsr_modulator_if #(
    parameter int SAMPLE_W = 12,
    parameter int PHASE_W  = 32
);
    logic [SAMPLE_W-1:0] sin_in;
    logic [SAMPLE_W-1:0] cos_in;
    logic [PHASE_W-1:0]  inc_0;
    logic [PHASE_W-1:0]  inc_1;
    logic [1:0]          mod_sel;
    logic [SAMPLE_W-1:0] mod_out;
    logic [PHASE_W-1:0]  phase_inc_out;
    logic [1:0]          sym;
    logic                sym_valid;

    modport master (
        output sin_in, cos_in, inc_0, inc_1, mod_sel,
        input  mod_out, phase_inc_out, sym, sym_valid
    );

    modport slave (
        input  sin_in, cos_in, inc_0, inc_1, mod_sel,
        output mod_out, phase_inc_out, sym, sym_valid
    );
endinterface

// File: rtl/lfsr_modulator_sync_edge_det.sv
// Brings the asynchronous lfsr_clk into the clk domain and flags its rising edge.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    // Next values: shift the input down the synchronizer, remember last synced level.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and edge-detect registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign pulse = sync2_q & ~prev_q;
endmodule

// File: rtl/lfsr_modulator.sv
// Latches a 2-bit symbol from a slow LFSR and uses it to modulate DDS samples.
//
// state   | meaning
// IDLE    | waiting for a synchronized lfsr_clk rising edge
// SETTLE  | letting lfsr_q settle for SETTLE_CYC clk cycles
// CAPTURE | new symbol is held in sym, sym_valid high for this cycle
module lfsr_modulator
    import lfsr_mod_pkg::*;
#(
    parameter int SAMPLE_W   = 12,
    parameter int PHASE_W    = 32,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lfsr_clk,
    input  logic [4:0]       lfsr_q,
    lfsr_modulator_if.slave  bus
);
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    fsm_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0] sym_q, sym_d;
    logic sym_valid_q, sym_valid_d;
    logic [SAMPLE_W-1:0] mod_out_q, mod_out_d;
    logic [PHASE_W-1:0] phase_inc_q, phase_inc_d;
    logic edge_pulse;
    mod_sel_e mod_sel;

    // Only the two low LFSR bits form the symbol.
    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_q[4:2];

    assign mod_sel = mod_sel_e'(bus.mod_sel);

    // Negation that maps the most negative code to the most positive one.
    function automatic logic [SAMPLE_W-1:0] sat_neg(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] min_val;
        min_val = {1'b1, {(SAMPLE_W-1){1'b0}}};
        return (x == min_val) ? ~x : (~x + 1'b1);
    endfunction

    sync_edge_det u_sync_edge_det (
        .clk   (clk),
        .reset (reset),
        .din   (lfsr_clk),
        .pulse (edge_pulse)
    );

    // Symbol sequencing; sym is loaded on entry to CAPTURE so it is visible during it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sym_d       = sym_q;
        sym_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_pulse) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = CAPTURE;
                    sym_d       = {lfsr_q[1], lfsr_q[0]};
                    sym_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Modulated sample and DDS phase increment from the currently held symbol.
    always_comb begin
        mod_out_d   = bus.sin_in;
        phase_inc_d = bus.inc_0;
        case (mod_sel)
            MOD_ASK:  mod_out_d = sym_q[0] ? bus.sin_in : '0;
            MOD_FSK: begin
                mod_out_d   = bus.sin_in;
                phase_inc_d = sym_q[0] ? bus.inc_1 : bus.inc_0;
            end
            MOD_BPSK: mod_out_d = sym_q[0] ? bus.sin_in : sat_neg(bus.sin_in);
            MOD_QPSK: begin
                case (sym_q)
                    2'b00:   mod_out_d = bus.sin_in;
                    2'b01:   mod_out_d = bus.cos_in;
                    2'b10:   mod_out_d = sat_neg(bus.sin_in);
                    default: mod_out_d = sat_neg(bus.cos_in);
                endcase
            end
            default:  mod_out_d = bus.sin_in;
        endcase
    end

    // All state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
            mod_out_q   <= '0;
            phase_inc_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            mod_out_q   <= mod_out_d;
            phase_inc_q <= phase_inc_d;
        end
    end

    assign bus.mod_out       = mod_out_q;
    assign bus.phase_inc_out = phase_inc_q;
    assign bus.sym           = sym_q;
    assign bus.sym_valid     = sym_valid_q;
endmodule

// File: tb/tb_lfsr_modulator.sv
// Scoreboard bench for lfsr_modulator: expected samples queued at drive, checked after the edge.
module tb_lfsr_modulator;
    import lfsr_mod_pkg::*;

    localparam int SW = 12;
    localparam int PW = 32;
    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lfsr_clk = 1'b0;
    logic [4:0] lfsr_q = 5'd0;

    lfsr_modulator_if #(.SAMPLE_W(SW), .PHASE_W(PW)) bus ();

    lfsr_modulator #(.SAMPLE_W(SW), .PHASE_W(PW), .SETTLE_CYC(SC)) dut (
        .clk      (clk),
        .reset    (reset),
        .lfsr_clk (lfsr_clk),
        .lfsr_q   (lfsr_q),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [SW-1:0] mod;
        logic [PW-1:0] inc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] m_sym = 2'b00;
    logic [1:0] pend = 2'b00;
    int         cd = 0;
    bit         rnd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] neg_sat(input logic [SW-1:0] x);
        return (x == 12'h800) ? 12'h7FF : (12'd0 - x);
    endfunction

    function automatic logic [SW-1:0] model_mod(input logic [1:0] sel, input logic [1:0] s,
                                                input logic [SW-1:0] sn, input logic [SW-1:0] cs);
        case (sel)
            2'd0: return s[0] ? sn : 12'd0;
            2'd1: return sn;
            2'd2: return s[0] ? sn : neg_sat(sn);
            default: begin
                case (s)
                    2'b00: return sn;
                    2'b01: return cs;
                    2'b10: return neg_sat(sn);
                    default: return neg_sat(cs);
                endcase
            end
        endcase
    endfunction

    task automatic step();
        exp_t e;
        logic exp_v;
        if (rnd) begin
            bus.sin_in = SW'($urandom);
            bus.cos_in = SW'($urandom);
        end
        e.mod = reset ? '0 : model_mod(bus.mod_sel, m_sym, bus.sin_in, bus.cos_in);
        e.inc = reset ? '0 : ((bus.mod_sel == 2'd1 && m_sym[0]) ? bus.inc_1 : bus.inc_0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        exp_v = 1'b0;
        if (reset) begin
            cd    = 0;
            m_sym = 2'b00;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                exp_v = 1'b1;
                m_sym = pend;
            end
        end
        e = sb.pop_front();
        chk("mod_out", 32'(bus.mod_out), 32'(e.mod));
        chk("phase_inc_out", bus.phase_inc_out, e.inc);
        chk("sym_valid", 32'(bus.sym_valid), 32'(exp_v));
        chk("sym", 32'(bus.sym), 32'(m_sym));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Edge reaches sym_valid after 2 sync + 1 detect + SC settle cycles.
    task automatic send_sym(input logic [4:0] q);
        lfsr_q   = q;
        pend     = q[1:0];
        lfsr_clk = 1'b1;
        cd       = 2 + 1 + SC;
        run(16);
        lfsr_clk = 1'b0;
        run(16);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mod_out"}, 32'(bus.mod_out), 32'd0);
        chk({tag, "_phase_inc"}, bus.phase_inc_out, 32'd0);
        chk({tag, "_sym"}, 32'(bus.sym), 32'd0);
        chk({tag, "_sym_valid"}, 32'(bus.sym_valid), 32'd0);
    endtask

    initial begin
        bus.sin_in  = 12'd0;
        bus.cos_in  = 12'd0;
        bus.inc_0   = 32'h0000_1000;
        bus.inc_1   = 32'h0000_2000;
        bus.mod_sel = 2'd2;
        #2 reset = 1'b1;
        #2 chk_all_zero("reset");
        run(2);
        reset = 1'b0;

        // BPSK, sym 00, most negative sine saturates.
        bus.sin_in = 12'h800;
        run(2);

        // ASK with b0 = 0 gives zero for any sine.
        bus.mod_sel = 2'd0;
        rnd = 1'b1;
        run(4);

        // Symbol 11 latched once, ASK then passes the sine.
        send_sym(5'b00011);

        // QPSK fixed samples.
        rnd = 1'b0;
        bus.mod_sel = 2'd3;
        bus.sin_in  = 12'd100;
        bus.cos_in  = 12'hED4;
        send_sym(5'b10101);
        send_sym(5'b01011);
        bus.cos_in = 12'h800;
        run(2);

        // FSK increments toggle with b0.
        rnd = 1'b1;
        bus.mod_sel = 2'd1;
        send_sym(5'b00000);
        send_sym(5'b00001);
        send_sym(5'b11100);
        send_sym(5'b00111);

        // BPSK with b0 = 0 negates random samples; sym 10 under ASK is zero.
        bus.mod_sel = 2'd2;
        send_sym(5'b00010);
        bus.mod_sel = 2'd0;
        run(4);

        // Mode changes each cycle without touching the symbol.
        for (int i = 0; i < 8; i++) begin
            bus.mod_sel = 2'(i);
            step();
        end

        // Reset two cycles into SETTLE discards the pending capture.
        bus.mod_sel = 2'd3;
        lfsr_q   = 5'b00011;
        pend     = 2'b11;
        lfsr_clk = 1'b1;
        cd       = 2 + 1 + SC;
        run(5);
        reset = 1'b1;
        #1 chk_all_zero("mid_settle_reset");
        m_sym    = 2'b00;
        cd       = 0;
        lfsr_clk = 1'b0;
        run(3);
        reset = 1'b0;
        run(20);

        // Next edge after reset captures normally.
        send_sym(5'b00001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_modulator.md
LFSR_MODULATOR -- requirements
Module: lfsr_modulator

Interface
REQ-001 Parameter SAMPLE_W, default 12: width of signed DDS sample inputs and modulated output.
REQ-002 Parameter PHASE_W, default 32: width of DDS phase-increment words.
REQ-003 Parameter SETTLE_CYC, default 4: clk cycles waited after a detected lfsr_clk rising edge before lfsr_q is captured.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 lfsr_clk  in  1  slow clock of the upstream LFSR; asynchronous to clk.
REQ-007 lfsr_q  in  5  LFSR state; changes only on rising edges of lfsr_clk.
REQ-008 sin_in  in  SAMPLE_W  signed DDS sine sample, valid every clk.
REQ-009 cos_in  in  SAMPLE_W  signed DDS cosine sample, valid every clk.
REQ-010 inc_0  in  PHASE_W  FSK phase increment for symbol bit 0.
REQ-011 inc_1  in  PHASE_W  FSK phase increment for symbol bit 1.
REQ-012 mod_sel  in  2  modulation select: 0 = ASK, 1 = FSK, 2 = BPSK, 3 = QPSK.
REQ-013 mod_out  out  SAMPLE_W  signed modulated sample, registered.
REQ-014 phase_inc_out  out  PHASE_W  phase increment returned to the DDS, registered.
REQ-015 sym  out  2  currently held symbol {b1,b0}.
REQ-016 sym_valid  out  1  one-clk pulse when a new symbol is latched.

Function
REQ-017 lfsr_clk SHALL pass through a 2-flop synchronizer, then a rising-edge detector on the synchronized signal.
REQ-018 FSM states SHALL be IDLE, SETTLE, CAPTURE.
- IDLE: stays until an edge is detected, then -> SETTLE with counter cleared.
- SETTLE: counts up to SETTLE_CYC-1, then -> CAPTURE.
- CAPTURE: one cycle, then -> IDLE.
REQ-019 In CAPTURE, sym SHALL load {lfsr_q[1], lfsr_q[0]}, and sym_valid SHALL be high for exactly that cycle.
REQ-020 An lfsr_clk edge detected while in SETTLE or CAPTURE SHALL be ignored; lfsr_clk period is at least 4*(SETTLE_CYC+4) clk cycles.
REQ-021 mod_out SHALL be registered with 1-clk latency from sin_in/cos_in and the current sym/mod_sel:
- ASK: b0 ? sin : 0
- FSK: sin
- BPSK: b0 ? sin : -sin
- QPSK: by {b1,b0}: 00 sin, 01 cos, 10 -sin, 11 -cos
REQ-022 Negation SHALL saturate: the most negative value maps to the most positive value (SAMPLE_W=12: -2048 -> 2047).
REQ-023 phase_inc_out SHALL be registered: b0 ? inc_1 : inc_0 when mod_sel = FSK; inc_0 for all other modes.
REQ-024 A mod_sel change SHALL take effect on the next clk edge, with no effect on FSM or sym.
REQ-025 A new sym SHALL affect mod_out and phase_inc_out starting the clk after CAPTURE.

Reset
REQ-026 reset SHALL asynchronously force:
- FSM to IDLE, counter to 0, synchronizer and edge-detect flops to 0
- sym = 0, sym_valid = 0, mod_out = 0, phase_inc_out = 0
REQ-027 After reset deasserts, the first registered outputs SHALL follow REQ-021/REQ-023 with sym = 0. A reset mid-SETTLE SHALL discard the pending capture.

Structure
REQ-028 A shared package lfsr_mod_pkg SHALL hold the mod_sel enum (MOD_ASK, MOD_FSK, MOD_BPSK, MOD_QPSK) and the FSM state enum.
REQ-029 The synchronizer plus edge detector SHALL be a sub-module, sync_edge_det (in, out pulse).

Verification
REQ-030 The bench SHALL cover these scenarios (SAMPLE_W=12, SETTLE_CYC=4):
- lfsr_clk rising with lfsr_q=5'b00011: sym_valid pulses exactly once, 2+1+4 clk cycles after the edge (2-flop sync, edge detect, settle); sym=2'b11 thereafter.
- mod_sel=BPSK, sym=00, sin_in=-2048: mod_out=2047 the next clk.
- mod_sel=QPSK, sin_in=100, cos_in=-300: sym 01 -> mod_out=-300; sym 11 -> mod_out=300.
- mod_sel=FSK, inc_0=0x0000_1000, inc_1=0x0000_2000, sym toggling 0/1: phase_inc_out alternates 0x1000/0x2000 one clk after each CAPTURE.
- mod_sel=ASK, b0=0: mod_out=0 regardless of sin_in.
- reset asserted two cycles into SETTLE: all outputs 0 immediately, no sym_valid afterwards until the next lfsr_clk edge.
